// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues single-outstanding instruction memory reads and
// feeds the fetch-execute register, handling stalls, redirects with squash, and HALT.
module fetch_stage #(
    parameter int                 PC_W     = 10,
    parameter int                 INSTR_W  = 12,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [3:0]         HALT_OP  = 4'hF,
    parameter logic [INSTR_W-1:0] NOP      = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_plus_1_out,
    output logic               fe_write_en,
    output logic               fe_clear,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HAVE,
        S_HALT
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr_buf;
    logic               squash;

    logic               redirect_eff;
    logic               is_halt;
    logic               accept;
    logic               bubble_state;

    // Redirects are ignored in S_IDLE; everywhere else they win over everything.
    assign redirect_eff  = redirect_valid && (state != S_IDLE);
    assign is_halt       = (instr_buf[INSTR_W-1 -: 4] == HALT_OP);
    assign bubble_state  = (state == S_REQ) || (state == S_WAIT) || (state == S_HALT);

    assign imem_req      = (state == S_REQ) && !redirect_valid;
    assign accept        = imem_req && imem_ready;
    assign imem_addr     = pc;
    assign pc_plus_1_out = pc + PC_W'(1);
    assign instr_out     = (state == S_HAVE) ? instr_buf : NOP;
    assign fe_write_en   = (state == S_HAVE) && !stall && !redirect_valid;
    assign fe_clear      = redirect_eff || (!stall && bubble_state);
    assign halted        = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            instr_buf <= NOP;
            squash    <= 1'b0;
        end else if (state == S_IDLE) begin
            state <= S_REQ;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            instr_buf <= NOP;
            // The in-flight response still has to be absorbed before a new request.
            if ((state == S_WAIT) && !imem_valid) begin
                squash <= 1'b1;
            end else begin
                squash <= 1'b0;
                state  <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        if (squash) begin
                            squash <= 1'b0;
                            state  <= S_REQ;
                        end else begin
                            instr_buf <= imem_rdata;
                            state     <= S_HAVE;
                        end
                    end
                end
                S_HAVE: begin
                    if (!stall) begin
                        pc    <= pc + PC_W'(1);
                        state <= is_halt ? S_HALT : S_REQ;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a latency-configurable imem responder plus a scoreboard
// of expected {instr, pc+1} pairs popped whenever the DUT loads the FE register.
module tb_fetch_stage;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic               imem_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               stall;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_plus_1_out;
    logic               fe_write_en;
    logic               fe_clear;
    logic               halted;

    logic [INSTR_W-1:0]      mem [0:1023];
    int                      mem_lat = 1;
    bit                      pend = 1'b0;
    logic [PC_W-1:0]         pend_addr = '0;
    int                      pend_wait = 0;
    logic [INSTR_W+PC_W-1:0] exp_q [$];
    logic [INSTR_W+PC_W-1:0] exp_e;
    int                      checks = 0;
    int                      passed = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_out      (instr_out),
        .pc_plus_1_out  (pc_plus_1_out),
        .fe_write_en    (fe_write_en),
        .fe_clear       (fe_clear),
        .halted         (halted)
    );

    // Memory responder: one response mem_lat cycles after each accepted request.
    always @(negedge clk) begin
        if (pend && pend_wait == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[pend_addr];
            pend       = 1'b0;
        end else begin
            imem_valid = 1'b0;
            if (pend) pend_wait--;
        end
        #2;
        if (rst) begin
            pend       = 1'b0;
            imem_valid = 1'b0;
        end else if (imem_req && imem_ready) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_wait = mem_lat - 1;
        end
    end

    // Scoreboard: every FE register load must match the oldest expected pair.
    always @(negedge clk) begin
        #1;
        if (!rst && fe_write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL sb_extra_write: got %h/%h, expected no write", instr_out, pc_plus_1_out);
            end else begin
                exp_e = exp_q.pop_front();
                if ({instr_out, pc_plus_1_out} !== exp_e)
                    $display("[TB] FAIL sb_write: got %h/%h, expected %h/%h", instr_out, pc_plus_1_out,
                             exp_e[PC_W +: INSTR_W], exp_e[PC_W-1:0]);
                else passed++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks so far %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) $display("[TB] FAIL rst_req: got %b expected 0", imem_req); else passed++;
        checks++; if (imem_addr !== 10'h000) $display("[TB] FAIL rst_addr: got %h expected 000", imem_addr); else passed++;
        checks++; if (instr_out !== 12'h000) $display("[TB] FAIL rst_instr: got %h expected 000", instr_out); else passed++;
        checks++; if (pc_plus_1_out !== 10'h001) $display("[TB] FAIL rst_pc1: got %h expected 001", pc_plus_1_out); else passed++;
        checks++; if (fe_write_en !== 1'b0) $display("[TB] FAIL rst_we: got %b expected 0", fe_write_en); else passed++;
        checks++; if (fe_clear !== 1'b0) $display("[TB] FAIL rst_clear: got %b expected 0", fe_clear); else passed++;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL rst_halted: got %b expected 0", halted); else passed++;
    endtask

    task automatic test_sequential();
        mem[0] = 12'h1A0;
        mem[1] = 12'h2B1;
        mem_lat = 1;
        exp_q.push_back({12'h1A0, 10'h001});
        exp_q.push_back({12'h2B1, 10'h002});
        @(negedge clk); rst = 1'b0; imem_ready = 1'b1; #1;
        checks++; if (fe_clear !== 1'b0) $display("[TB] FAIL seq_idle_clear: got %b expected 0", fe_clear); else passed++;
        checks++; if (imem_req !== 1'b0) $display("[TB] FAIL seq_idle_req: got %b expected 0", imem_req); else passed++;
        @(negedge clk); #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h000}) $display("[TB] FAIL seq_req0: got %b/%h expected 1/000", imem_req, imem_addr); else passed++;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (fe_write_en !== 1'b1) $display("[TB] FAIL seq_we_c3: got %b expected 1", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h001}) $display("[TB] FAIL seq_req1: got %b/%h expected 1/001", imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0; #1;
        checks++; if (fe_write_en !== 1'b0) $display("[TB] FAIL seq_we_c5: got %b expected 0", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if (fe_write_en !== 1'b1) $display("[TB] FAIL seq_we_c6: got %b expected 1", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL seq_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_stall();
        exp_q.push_back({12'h1A0, 10'h001});
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 10'h000; #1;
        checks++; if (fe_clear !== 1'b1) $display("[TB] FAIL stall_redir_clear: got %b expected 1", fe_clear); else passed++;
        @(negedge clk); redirect_valid = 1'b0; stall = 1'b1; imem_ready = 1'b1; #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h000}) $display("[TB] FAIL stall_req: got %b/%h expected 1/000", imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); if (i == 0) imem_ready = 1'b1; #1;
            checks++; if ({fe_write_en, fe_clear, imem_req} !== 3'b000) $display("[TB] FAIL stall_hold_ctl: got we/clr/req %b expected 000", {fe_write_en, fe_clear, imem_req}); else passed++;
            checks++; if (instr_out !== 12'h1A0) $display("[TB] FAIL stall_hold_instr: got %h expected 1a0", instr_out); else passed++;
        end
        @(negedge clk); stall = 1'b0; imem_ready = 1'b0; #1;
        checks++; if (fe_write_en !== 1'b1) $display("[TB] FAIL stall_resume: got %b expected 1", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL stall_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_redirect_wait();
        mem[1] = 12'h3C3;
        mem[10'h155] = 12'h4D4;
        mem_lat = 3;
        exp_q.push_back({12'h4D4, 10'h156});
        @(negedge clk); imem_ready = 1'b1; #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h001}) $display("[TB] FAIL rw_req: got %b/%h expected 1/001", imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h155; #1;
        checks++; if ({fe_clear, fe_write_en} !== 2'b10) $display("[TB] FAIL rw_redir_ctl: got clr/we %b expected 10", {fe_clear, fe_write_en}); else passed++;
        @(negedge clk); redirect_valid = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) $display("[TB] FAIL rw_wait_req: got %b expected 0", imem_req); else passed++;
        @(negedge clk); #1;
        checks++; if ({fe_write_en, imem_req} !== 2'b00) $display("[TB] FAIL rw_squash: got we/req %b expected 00", {fe_write_en, imem_req}); else passed++;
        @(negedge clk); mem_lat = 1; imem_ready = 1'b1; #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h155}) $display("[TB] FAIL rw_newaddr: got %b/%h expected 1/155", imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (fe_write_en !== 1'b1) $display("[TB] FAIL rw_we: got %b expected 1", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL rw_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_redirect_coincident();
        mem[10'h156] = 12'h5E5;
        mem[10'h300] = 12'h7B7;
        @(negedge clk); imem_ready = 1'b1; #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h156}) $display("[TB] FAIL rc_req: got %b/%h expected 1/156", imem_req, imem_addr); else passed++;
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 10'h200; #1;
        checks++; if ({fe_clear, fe_write_en} !== 2'b10) $display("[TB] FAIL rc_valid_redir: got clr/we %b expected 10", {fe_clear, fe_write_en}); else passed++;
        @(negedge clk); redirect_pc = 10'h300; #1;
        checks++; if ({imem_req, fe_clear} !== 2'b01) $display("[TB] FAIL rc_ready_redir: got req/clr %b expected 01", {imem_req, fe_clear}); else passed++;
        @(negedge clk); redirect_valid = 1'b0; exp_q.push_back({12'h7B7, 10'h301}); #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h300}) $display("[TB] FAIL rc_newaddr: got %b/%h expected 1/300", imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (fe_write_en !== 1'b1) $display("[TB] FAIL rc_we: got %b expected 1", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if (fe_write_en !== 1'b0) $display("[TB] FAIL rc_no_extra: got %b expected 0", fe_write_en); else passed++;
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL rc_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_wrap();
        mem[10'h3FF] = 12'h0C1;
        mem[0] = 12'h1A0;
        exp_q.push_back({12'h0C1, 10'h000});
        exp_q.push_back({12'h1A0, 10'h001});
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 10'h3FF;
        @(negedge clk); redirect_valid = 1'b0; imem_ready = 1'b1; #1;
        checks++; if ({imem_addr, pc_plus_1_out} !== {10'h3FF, 10'h000}) $display("[TB] FAIL wrap_pc: got %h/%h expected 3ff/000", imem_addr, pc_plus_1_out); else passed++;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (fe_write_en !== 1'b1) $display("[TB] FAIL wrap_we: got %b expected 1", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h000}) $display("[TB] FAIL wrap_next: got %b/%h expected 1/000", imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (fe_write_en !== 1'b1) $display("[TB] FAIL wrap_we2: got %b expected 1", fe_write_en); else passed++;
        @(negedge clk); #1;
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL wrap_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_halt_and_reset();
        mem[10'h040] = 12'hF00;
        mem[10'h010] = 12'h2C2;
        exp_q.push_back({12'hF00, 10'h041});
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 10'h040;
        @(negedge clk); redirect_valid = 1'b0; imem_ready = 1'b1; #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 10'h040}) $display("[TB] FAIL halt_req: got %b/%h expected 1/040", imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if ({fe_write_en, halted} !== 2'b10) $display("[TB] FAIL halt_write: got we/halted %b expected 10", {fe_write_en, halted}); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); imem_ready = 1'b1; #1;
            checks++; if ({halted, imem_req, fe_clear, fe_write_en} !== 4'b1010) $display("[TB] FAIL halt_park: got halted/req/clr/we %b expected 1010", {halted, imem_req, fe_clear, fe_write_en}); else passed++;
        end
        @(negedge clk); stall = 1'b1; #1;
        checks++; if ({halted, fe_clear} !== 2'b10) $display("[TB] FAIL halt_stall: got halted/clr %b expected 10", {halted, fe_clear}); else passed++;
        @(negedge clk); stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h010; #1;
        checks++; if (fe_clear !== 1'b1) $display("[TB] FAIL halt_redir_clear: got %b expected 1", fe_clear); else passed++;
        @(negedge clk); redirect_valid = 1'b0; mem_lat = 3; #1;
        checks++; if ({halted, imem_req, imem_addr} !== {2'b01, 10'h010}) $display("[TB] FAIL halt_resume: got %b/%b/%h expected 0/1/010", halted, imem_req, imem_addr); else passed++;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        checks++; if ({imem_req, fe_write_en, fe_clear, halted} !== 4'b0000) $display("[TB] FAIL midrst_ctl: got req/we/clr/halted %b expected 0000", {imem_req, fe_write_en, fe_clear, halted}); else passed++;
        checks++; if ({imem_addr, pc_plus_1_out} !== {10'h000, 10'h001}) $display("[TB] FAIL midrst_pc: got %h/%h expected 000/001", imem_addr, pc_plus_1_out); else passed++;
        checks++; if (instr_out !== 12'h000) $display("[TB] FAIL midrst_instr: got %h expected 000", instr_out); else passed++;
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL halt_drain: got %0d pending expected 0", exp_q.size()); else passed++;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ready     = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_halt_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
